// File: rtl/io_mmio_fifo_if.sv
`default_nettype none
// ============================================================================
// Module  : io_mmio_fifo_if
// Purpose : CPU MMIO load/store port plus UART TX/RX byte handshakes.
// Revision: 1.0
// ============================================================================
interface io_mmio_fifo_if #(
  parameter int DATA_W = 8
);
  logic [31:0]       addr;
  logic              wr_en;
  logic [31:0]       wr_data;
  logic              rd_en;
  logic [31:0]       rd_data;
  logic              io_sel;
  logic              instr_retire;
  logic [DATA_W-1:0] uart_tx_data;
  logic              uart_tx_valid;
  logic              uart_tx_ready;
  logic [DATA_W-1:0] uart_rx_data;
  logic              uart_rx_valid;
  logic              uart_rx_ready;

  // master = CPU core plus UART side; slave = the MMIO FIFO block
  modport master (
    output addr, wr_en, wr_data, rd_en, instr_retire,
    output uart_tx_ready, uart_rx_data, uart_rx_valid,
    input  rd_data, io_sel, uart_tx_data, uart_tx_valid, uart_rx_ready
  );

  modport slave (
    input  addr, wr_en, wr_data, rd_en, instr_retire,
    input  uart_tx_ready, uart_rx_data, uart_rx_valid,
    output rd_data, io_sel, uart_tx_data, uart_tx_valid, uart_rx_ready
  );
endinterface
`default_nettype wire

// File: rtl/io_mmio_fifo.sv
`default_nettype none
// ============================================================================
// Module  : io_mmio_fifo
// Purpose : Memory-mapped UART TX/RX FIFOs with cycle and retire counters.
// Revision: 1.0
// ============================================================================
module io_mmio_fifo #(
  parameter int DATA_W   = 8,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  wire logic     clk,
  input  wire logic     rst,
  io_mmio_fifo_if.slave bus
);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_CW = TX_AW + 1;
  localparam int RX_CW = RX_AW + 1;

  localparam logic [2:0] REG_RX_STAT   = 3'd0;
  localparam logic [2:0] REG_RX_DATA   = 3'd1;
  localparam logic [2:0] REG_TX_STAT   = 3'd2;
  localparam logic [2:0] REG_TX_DATA   = 3'd3;
  localparam logic [2:0] REG_CYCLE     = 3'd4;
  localparam logic [2:0] REG_INSTR     = 3'd5;
  localparam logic [2:0] REG_CLEAR     = 3'd6;
  localparam logic [2:0] REG_FIFO_STAT = 3'd7;

  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [TX_AW-1:0]  tx_wptr, tx_rptr;
  logic [RX_AW-1:0]  rx_wptr, rx_rptr;
  logic [TX_CW-1:0]  tx_count;
  logic [RX_CW-1:0]  rx_count;
  logic [31:0]       cycle_cnt, instr_cnt;
  logic              tx_overflow, rx_underflow;

  logic [2:0]  reg_idx;
  logic        cpu_wr, cpu_rd;
  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic        tx_push_req, tx_push, tx_pop, tx_ovf_evt;
  logic        rx_pop_req, rx_push, rx_pop, rx_unf_evt;
  logic        flag_clr, cnt_clr;
  logic [31:0] rd_mux;
  logic        unused_bits;

  assign reg_idx  = bus.addr[4:2];
  assign cpu_wr   = bus.wr_en & bus.addr[31];
  assign cpu_rd   = bus.rd_en & bus.addr[31];
  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == TX_CW'(TX_DEPTH));
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));

  // A full TX FIFO still accepts a write when the UART drains a slot on the same edge
  assign tx_pop      = ~tx_empty & bus.uart_tx_ready;
  assign tx_push_req = cpu_wr & (reg_idx == REG_TX_DATA);
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign tx_ovf_evt  = tx_push_req & tx_full & ~tx_pop;

  assign rx_push    = bus.uart_rx_valid & ~rx_full;
  assign rx_pop_req = cpu_rd & (reg_idx == REG_RX_DATA);
  assign rx_pop     = rx_pop_req & ~rx_empty;
  assign rx_unf_evt = rx_pop_req & rx_empty;

  assign flag_clr = cpu_wr & (reg_idx == REG_FIFO_STAT);
  assign cnt_clr  = cpu_wr & (reg_idx == REG_CLEAR);

  assign bus.io_sel        = bus.addr[31];
  assign bus.uart_tx_valid = ~tx_empty;
  assign bus.uart_tx_data  = tx_mem[tx_rptr];
  assign bus.uart_rx_ready = ~rx_full;
  assign bus.rd_data       = rd_mux;

  assign unused_bits = ^{bus.addr[30:5], bus.addr[1:0], bus.wr_data[31:DATA_W]};

  always_comb begin
    rd_mux = '0;
    if (bus.addr[31]) begin
      case (reg_idx)
        REG_RX_STAT:   rd_mux = {31'b0, ~rx_empty};
        REG_RX_DATA:   rd_mux = rx_empty ? '0 : 32'(rx_mem[rx_rptr]);
        REG_TX_STAT:   rd_mux = {31'b0, ~tx_full};
        REG_CYCLE:     rd_mux = cycle_cnt;
        REG_INSTR:     rd_mux = instr_cnt;
        REG_FIFO_STAT: rd_mux = {8'(rx_count), 8'(tx_count), 14'b0, rx_underflow, tx_overflow};
        default:       rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= bus.wr_data[DATA_W-1:0];
    if (rx_push) rx_mem[rx_wptr] <= bus.uart_rx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + TX_AW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + TX_AW'(1);
      if (rx_push) rx_wptr <= rx_wptr + RX_AW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + RX_AW'(1);
      tx_count <= tx_count + TX_CW'(tx_push) - TX_CW'(tx_pop);
      rx_count <= rx_count + RX_CW'(rx_push) - RX_CW'(rx_pop);
    end
  end

  // A new event on the clearing edge wins so no overflow/underflow is lost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
      cycle_cnt    <= '0;
      instr_cnt    <= '0;
    end else begin
      tx_overflow  <= tx_ovf_evt | (tx_overflow & ~flag_clr);
      rx_underflow <= rx_unf_evt | (rx_underflow & ~flag_clr);
      if (cnt_clr) begin
        cycle_cnt <= '0;
        instr_cnt <= '0;
      end else begin
        cycle_cnt <= cycle_cnt + 32'd1;
        instr_cnt <= instr_cnt + 32'(bus.instr_retire);
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_io_mmio_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_io_mmio_fifo
// Purpose : Directed bench for io_mmio_fifo with a queue-based reference model.
// Revision: 1.0
// ============================================================================
module tb_io_mmio_fifo;
  localparam int DW  = 8;
  localparam int TXD = 8;
  localparam int RXD = 8;
  localparam logic [31:0] A_RXS = 32'h8000_0000, A_RXD = 32'h8000_0004;
  localparam logic [31:0] A_TXS = 32'h8000_0008, A_TXD = 32'h8000_000C;
  localparam logic [31:0] A_CYC = 32'h8000_0010, A_INS = 32'h8000_0014;
  localparam logic [31:0] A_CLR = 32'h8000_0018, A_STS = 32'h8000_001C;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  io_mmio_fifo_if #(.DATA_W(DW)) bus();
  io_mmio_fifo #(.DATA_W(DW), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  // Reference model: plain queues and counters updated from the bus rules
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [31:0] m_cyc = 32'd0, m_ins = 32'd0;
  logic        m_ovf = 1'b0, m_unf = 1'b0;
  logic        preload = 1'b0;

  always @(posedge clk or negedge rst or posedge preload) begin
    if (!rst) begin
      tx_q.delete(); rx_q.delete();
      m_cyc = 0; m_ins = 0; m_ovf = 0; m_unf = 0;
    end else if (preload) begin
      m_cyc = 32'hFFFF_FFFF;
    end else begin
      int idx;
      bit wr, rd, tx_pop, push_req, ovf_evt, rx_push, pop_req, unf_evt;
      idx      = int'(bus.addr[4:2]);
      wr       = bus.addr[31] && bus.wr_en;
      rd       = bus.addr[31] && bus.rd_en;
      tx_pop   = (tx_q.size() != 0) && bus.uart_tx_ready;
      push_req = wr && idx == 3;
      ovf_evt  = push_req && tx_q.size() == TXD && !tx_pop;
      rx_push  = bus.uart_rx_valid && rx_q.size() < RXD;
      pop_req  = rd && idx == 1;
      unf_evt  = pop_req && rx_q.size() == 0;
      if (tx_pop) void'(tx_q.pop_front());
      if (push_req && !ovf_evt) tx_q.push_back(bus.wr_data[7:0]);
      if (pop_req && rx_q.size() != 0) void'(rx_q.pop_front());
      if (rx_push) rx_q.push_back(bus.uart_rx_data);
      m_ovf = ovf_evt || (m_ovf && !(wr && idx == 7));
      m_unf = unf_evt || (m_unf && !(wr && idx == 7));
      if (wr && idx == 6) begin
        m_cyc = 0; m_ins = 0;
      end else begin
        m_cyc = m_cyc + 1;
        m_ins = m_ins + 32'(bus.instr_retire);
      end
    end
  end

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    logic [31:0] v;
    v = 0;
    if (a[31]) begin
      case (a[4:2])
        3'd0: v = (rx_q.size() != 0) ? 32'd1 : 32'd0;
        3'd1: v = (rx_q.size() != 0) ? 32'(rx_q[0]) : 32'd0;
        3'd2: v = (tx_q.size() < TXD) ? 32'd1 : 32'd0;
        3'd4: v = m_cyc;
        3'd5: v = m_ins;
        3'd7: v = (32'(rx_q.size()) << 24) | (32'(tx_q.size()) << 16)
                | (32'(m_unf) << 1) | 32'(m_ovf);
        default: v = 0;
      endcase
    end
    return v;
  endfunction

  // Literal expectations posted by the stimulus for the current cycle
  bit          lit_on [2];
  int          lit_sel[2];
  logic [31:0] lit_exp[2];
  string       lit_nm [2];

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      0:       return bus.rd_data;
      1:       return {31'b0, bus.uart_tx_valid};
      2:       return 32'(bus.uart_tx_data);
      3:       return {31'b0, bus.uart_rx_ready};
      default: return {31'b0, bus.io_sel};
    endcase
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("tx_valid", {31'b0, bus.uart_tx_valid}, {31'b0, tx_q.size() != 0});
    check("rx_ready", {31'b0, bus.uart_rx_ready}, {31'b0, rx_q.size() < RXD});
    check("io_sel", {31'b0, bus.io_sel}, {31'b0, bus.addr[31]});
    if (tx_q.size() != 0) check("tx_data", 32'(bus.uart_tx_data), 32'(tx_q[0]));
    if (bus.rd_en || !bus.addr[31]) check("rd_data", bus.rd_data, m_rd(bus.addr));
    for (int k = 0; k < 2; k++)
      if (lit_on[k]) check(lit_nm[k], pick(lit_sel[k]), lit_exp[k]);
  end

  task automatic lit(input int s, input string nm, input int sel, input logic [31:0] e);
    lit_on[s] = 1'b1; lit_nm[s] = nm; lit_sel[s] = sel; lit_exp[s] = e;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    lit_on[0] = 1'b0;
    lit_on[1] = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr = a; bus.wr_en = 1'b1; bus.wr_data = d;
    next();
    bus.wr_en = 1'b0; bus.addr = 32'd0;
  endtask

  task automatic rd(input logic [31:0] a, input string nm, input logic [31:0] e);
    bus.addr = a; bus.rd_en = 1'b1;
    lit(0, nm, 0, e);
    next();
    bus.rd_en = 1'b0; bus.addr = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.addr = 0; bus.wr_en = 0; bus.wr_data = 0; bus.rd_en = 0;
    bus.instr_retire = 0; bus.uart_tx_ready = 0;
    bus.uart_rx_data = 0; bus.uart_rx_valid = 0;
    lit_on[0] = 0; lit_on[1] = 0;
    @(posedge clk); #1;
    lit(0, "reset_tx_valid", 1, 0);
    lit(1, "reset_rx_ready", 3, 1);
    repeat (3) next();
    rst = 1'b1;
    repeat (2) next();

    // TX ordering: queue three bytes, then drain one per cycle
    wr(A_TXD, 32'h41); wr(A_TXD, 32'h42); wr(A_TXD, 32'h43);
    lit(0, "tx_hold_head", 2, 32'h41); lit(1, "tx_hold_valid", 1, 1); next();
    bus.uart_tx_ready = 1'b1;
    lit(0, "tx_seq0", 2, 32'h41); next();
    lit(0, "tx_seq1", 2, 32'h42); next();
    lit(0, "tx_seq2", 2, 32'h43); next();
    lit(0, "tx_drained", 1, 0); next();
    bus.uart_tx_ready = 1'b0;

    // TX full: dropped write, flag clear, then push while the UART pops
    for (int i = 0; i < 8; i++) wr(A_TXD, 32'h10 + i);
    rd(A_TXS, "tx_status_full", 0);
    wr(A_TXD, 32'h55);
    rd(A_STS, "ovf_status", 32'h0008_0001);
    wr(A_STS, 0);
    rd(A_STS, "ovf_cleared", 32'h0008_0000);
    bus.uart_tx_ready = 1'b1;
    wr(A_TXD, 32'h55);
    bus.uart_tx_ready = 1'b0;
    lit(1, "tx_head_after_pop", 2, 32'h11);
    rd(A_STS, "full_push_pop", 32'h0008_0000);
    bus.uart_tx_ready = 1'b1;
    repeat (7) next();
    lit(0, "tx_tail_55", 2, 32'h55); next();
    lit(0, "tx_empty", 1, 0); next();
    bus.uart_tx_ready = 1'b0;

    // RX single byte and underflow
    bus.uart_rx_data = 8'h7E; bus.uart_rx_valid = 1'b1; next(); bus.uart_rx_valid = 1'b0;
    rd(A_RXS, "rx_status", 1);
    rd(A_RXD, "rx_data", 32'h7E);
    rd(A_RXD, "rx_empty_read", 0);
    rd(A_STS, "unf_status", 32'h0000_0002);

    // RX fill to full with retire pulses on odd cycles
    bus.uart_rx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.uart_rx_data = 8'(8'hA0 + i);
      bus.instr_retire = i[0];
      next();
    end
    bus.instr_retire = 1'b0;
    lit(0, "rx_full_ready", 3, 0); next();
    bus.uart_rx_valid = 1'b0;
    bus.addr = 32'h1000_0004; bus.rd_en = 1'b1;
    lit(0, "io_sel_low", 4, 0); lit(1, "low_rd_zero", 0, 0); next();
    bus.rd_en = 1'b0; bus.addr = 0;
    rd(A_STS, "rx_count_kept", 32'h0800_0002);
    rd(A_RXD, "rx_head_a0", 32'hA0);
    wr(A_STS, 0);
    bus.addr = A_RXD; bus.rd_en = 1'b1; repeat (7) next();
    bus.rd_en = 1'b0; bus.addr = 0;
    rd(A_STS, "rx_drained", 0);

    // Counters: retire count, preload wrap, clear beats same-cycle retire
    rd(A_INS, "instr_count", 32'd4);
    bus.addr = A_CYC; bus.rd_en = 1'b1;
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    preload = 1'b1;
    lit(0, "cycle_preload", 0, 32'hFFFF_FFFF);
    @(negedge clk); #1;
    release dut.cycle_cnt;
    preload = 1'b0;
    next();
    lit(0, "cycle_wrap", 0, 0); next();
    bus.rd_en = 1'b0; bus.addr = 0;
    bus.instr_retire = 1'b1;
    wr(A_CLR, 0);
    bus.instr_retire = 1'b0;
    rd(A_CYC, "cycle_cleared", 0);
    rd(A_INS, "instr_cleared", 0);
    rd(A_CLR, "clear_reg_reads0", 0);

    // Asynchronous reset with TX data queued
    wr(A_TXD, 32'h01); wr(A_TXD, 32'h02); wr(A_TXD, 32'h03);
    bus.instr_retire = 1'b1; next(); bus.instr_retire = 1'b0;
    lit(0, "rst_async_valid", 1, 0); lit(1, "rst_rx_ready", 3, 1);
    #2 rst = 1'b0;
    next();
    next();
    rst = 1'b1;
    bus.addr = A_CYC; bus.rd_en = 1'b1;
    lit(0, "post_rst_cycle", 0, 0); lit(1, "post_rst_tx_empty", 1, 0); next();
    bus.addr = A_INS; lit(0, "post_rst_instr", 0, 0); next();
    bus.addr = A_STS; lit(0, "post_rst_status", 0, 0); next();
    bus.rd_en = 1'b0; bus.addr = 0;
    wr(A_TXD, 32'h5A);
    lit(0, "post_rst_tx_data", 2, 32'h5A); next();
    bus.uart_tx_ready = 1'b1; next(); bus.uart_tx_ready = 1'b0;
    repeat (2) next();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
